// File: rtl/parity_flag_acc.sv
// -----------------------------------------------------------------------------
// parity_flag_acc
//
// Registered, multi-beat parity flag generator. Accumulates parity over a
// packet of WIDTH-bit result words arriving on a valid/ready stream, optionally
// checks it against a supplied parity bit, and holds PF/PERR/OVF plus the beat
// count until the consumer accepts them.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   odd_mode            0: PF=1 for an even count of ones, 1: PF=1 for odd
//   check_en            compare in_par against PF on the last beat
//   in_valid/in_ready   beat handshake
//   in_data             WIDTH-bit result word
//   in_last             final beat of the packet
//   in_par              expected PF, sampled on the last beat only
//   out_valid/out_ready result handshake
//   PF, PERR, OVF       parity flag, parity mismatch, forced termination
//   beat_cnt            number of beats in the reported packet
// -----------------------------------------------------------------------------
module parity_flag_acc #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             odd_mode,
  input  logic             check_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             PF,
  output logic             PERR,
  output logic             OVF,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             chk_q, chk_d;
  logic             alive_q;

  logic             pf_q, pf_d;
  logic             perr_q, perr_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] bc_q, bc_d;

  // Per-beat datapath shared by IDLE and ACCUM.
  logic             accept;
  logic             first_beat;
  logic             mode_eff;
  logic             chk_eff;
  logic             acc_new;
  logic [CNT_W-1:0] cnt_new;
  logic             at_max;
  logic             term;
  logic             pf_new;

  // in_ready stays low until the first clock after reset release, and drops
  // for the whole HOLD state so a result and a new beat never overlap.
  assign in_ready  = alive_q & (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;

  // The first beat of a packet uses the live mode/check inputs; later beats
  // use the values latched on that first beat.
  assign first_beat = (state_q == IDLE);
  assign mode_eff   = first_beat ? odd_mode : mode_q;
  assign chk_eff    = first_beat ? check_en : chk_q;
  assign acc_new    = first_beat ? (^in_data) : (acc_q ^ (^in_data));
  assign cnt_new    = first_beat ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign at_max     = (cnt_new == CNT_W'(MAX_BEATS));
  assign term       = accept & (in_last | at_max);
  // acc_new is the XOR of all data bits, i.e. 1 for an odd count of ones.
  assign pf_new     = ~acc_new ^ mode_eff;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    chk_d   = chk_q;
    pf_d    = pf_q;
    perr_d  = perr_q;
    ovf_d   = ovf_q;
    bc_d    = bc_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d  = odd_mode;
          chk_d   = check_en;
          acc_d   = acc_new;
          cnt_d   = cnt_new;
          state_d = term ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = acc_new;
          cnt_d   = cnt_new;
          state_d = term ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Result registers only move when a packet terminates; between results
    // they keep the last reported values.
    if (term) begin
      pf_d   = pf_new;
      // An overflowed packet has no in_last, so in_par is never compared.
      perr_d = chk_eff & in_last & (in_par != pf_new);
      ovf_d  = at_max & ~in_last;
      bc_d   = cnt_new;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      chk_q   <= 1'b0;
      alive_q <= 1'b0;
      pf_q    <= 1'b0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      chk_q   <= chk_d;
      alive_q <= 1'b1;
      pf_q    <= pf_d;
      perr_q  <= perr_d;
      ovf_q   <= ovf_d;
      bc_q    <= bc_d;
    end
  end

  assign PF       = pf_q;
  assign PERR     = perr_q;
  assign OVF      = ovf_q;
  assign beat_cnt = bc_q;

endmodule

// File: tb/tb_parity_flag_acc.sv
// -----------------------------------------------------------------------------
// tb_parity_flag_acc
//
// Directed bench for parity_flag_acc with WIDTH=8, MAX_BEATS=4. Expected
// results come from a ones-count packet model and are queued when the
// terminating beat is accepted, then popped when the DUT presents a result.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_parity_flag_acc;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_BEATS = 4;
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);

  typedef struct packed {
    logic             pf;
    logic             perr;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             odd_mode, check_en;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last, in_par;
  logic             out_valid, out_ready;
  logic             PF, PERR, OVF;
  logic [CNT_W-1:0] beat_cnt;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t last_e;

  // Packet model: total ones count, beat count, and the latched mode/check.
  bit   m_idle = 1'b1;
  int   m_ones, m_cnt;
  bit   m_mode, m_chk;

  parity_flag_acc #(
    .WIDTH    (WIDTH),
    .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .odd_mode (odd_mode),
    .check_en (check_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_par   (in_par),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .PF       (PF),
    .PERR     (PERR),
    .OVF      (OVF),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic drive_beat(input logic [WIDTH-1:0] data, input bit last, input bit par,
                            input bit mode, input bit chk);
    int   n;
    exp_t e;
    bit   pf;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    in_par   = par;
    odd_mode = mode;
    check_en = chk;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("in_ready_timeout", in_ready, 1);
    end else begin
      @(posedge clk);
      if (m_idle) begin
        m_mode = mode;
        m_chk  = chk;
        m_ones = $countones(data);
        m_cnt  = 1;
        m_idle = 1'b0;
      end else begin
        m_ones += $countones(data);
        m_cnt++;
      end
      if (last || m_cnt == MAX_BEATS) begin
        pf     = ((m_ones % 2) == 0) ? ~m_mode : m_mode;
        e.pf   = pf;
        e.perr = m_chk && last && (par != pf);
        e.ovf  = (m_cnt == MAX_BEATS) && !last;
        e.cnt  = CNT_W'(m_cnt);
        sb.push_back(e);
        m_idle = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Compare the presented result against the scoreboard head.
  task automatic check_result(input string tag, input bit immediate);
    int n;
    n = 0;
    if (immediate) begin
      check({tag, "_valid_next_cycle"}, out_valid, 1);
    end else begin
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) check({tag, "_valid_timeout"}, out_valid, 1);
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, out_valid, 0);
    end else begin
      last_e = sb.pop_front();
      check({tag, "_pf"},   PF,       last_e.pf);
      check({tag, "_perr"}, PERR,     last_e.perr);
      check({tag, "_ovf"},  OVF,      last_e.ovf);
      check({tag, "_cnt"},  beat_cnt, last_e.cnt);
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_rel_valid"}, out_valid, 0);
    check({tag, "_rel_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [15:0] pf_tbl;
    pf_tbl    = 16'h9669;
    rst_n     = 1'b0;
    odd_mode  = 1'b0;
    check_en  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_par    = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    #2;
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_pf",        PF,        0);
    check("rst_perr",      PERR,      0);
    check("rst_ovf",       OVF,       0);
    check("rst_cnt",       beat_cnt,  0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", in_ready, 0);
    @(negedge clk);
    check("rel_in_ready_high", in_ready, 1);

    // Exhaustive single-beat nibbles, even mode.
    for (int i = 0; i < 16; i++) begin
      drive_beat(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      check_result("exh", 1'b1);
      check("exh_pf_table", PF, pf_tbl[i]);
      release_result("exh");
    end

    // Multi-beat 01,03,07 (6 ones) with idle gaps; mode change mid-packet ignored.
    drive_beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("mb_hold_no_valid", out_valid, 0);
    drive_beat(8'h03, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_beat(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
    check_result("mb_even", 1'b1);
    check("mb_even_pf_const",  PF,       1);
    check("mb_even_cnt_const", beat_cnt, 3);
    release_result("mb_even");
    drive_beat(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    drive_beat(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_beat(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    check_result("mb_odd", 1'b1);
    check("mb_odd_pf_const", PF, 0);

    // Backpressure: hold out_ready low with a beat pending.
    in_valid = 1'b1;
    in_data  = 8'h03;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid",    out_valid, 1);
      check("bp_in_ready", in_ready,  0);
      check("bp_pf",       PF,        last_e.pf);
      check("bp_cnt",      beat_cnt,  last_e.cnt);
    end
    release_result("bp");
    drive_beat(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    check_result("bp_next", 1'b1);
    release_result("bp_next");

    // Overflow: four beats without in_last, then the fifth starts a new packet.
    for (int b = 0; b < 4; b++) drive_beat(8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
    check_result("ovf", 1'b1);
    check("ovf_flag_const", OVF,      1);
    check("ovf_cnt_const",  beat_cnt, 4);
    check("ovf_pf_const",   PF,       1);
    check("ovf_perr_const", PERR,     0);
    release_result("ovf");
    drive_beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_beat(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    check_result("ovf_next", 1'b1);
    check("ovf_next_cnt_const", beat_cnt, 2);
    release_result("ovf_next");

    // in_last on exactly beat MAX_BEATS terminates normally.
    for (int b = 0; b < 3; b++) drive_beat(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_beat(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    check_result("last_at_max", 1'b1);
    check("last_at_max_ovf_const", OVF, 0);
    release_result("last_at_max");

    // Parity check: check_en=0, then in_par=1, then in_par=0 (mismatch).
    drive_beat(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check_result("chk_off", 1'b1);
    release_result("chk_off");
    drive_beat(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    check_result("chk_match", 1'b1);
    release_result("chk_match");
    drive_beat(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    check_result("chk_mismatch", 1'b1);
    check("chk_mismatch_perr_const", PERR, 1);
    release_result("chk_mismatch");

    // Reset mid-packet, asynchronously between edges.
    drive_beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pf",        PF,        0);
    check("arst_perr",      PERR,      0);
    check("arst_ovf",       OVF,       0);
    check("arst_cnt",       beat_cnt,  0);
    check("arst_in_ready",  in_ready,  0);
    check("arst_out_valid", out_valid, 0);
    m_idle = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_beat(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    check_result("post_rst", 1'b1);
    check("post_rst_pf_const",  PF,       0);
    check("post_rst_cnt_const", beat_cnt, 1);
    release_result("post_rst");

    check("sb_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
